// File: rtl/fifo_rd_streamer.sv
// Drains a synchronous FIFO read port into a valid/ready stream through a
// 2-entry skid buffer; reads are issued only when a buffer slot is guaranteed.
module fifo_rd_streamer #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    logic [1:0]            occ;
    logic                  inflight_q;
    logic [FIFO_WIDTH-1:0] buf_head;
    logic [FIFO_WIDTH-1:0] buf_tail;
    logic                  pop;
    logic                  capture;
    logic [2:0]            committed;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_head;
    assign pop     = m_valid && m_ready;
    assign capture = inflight_q && !fifo_underflow;

    // Slots already spoken for after this cycle's pop; a read is only issued
    // if its returning word is guaranteed a place in the buffer.
    assign committed  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = !rst && enable && !fifo_empty && (committed < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            occ           <= 2'd0;
            inflight_q    <= 1'b0;
            buf_head      <= '0;
            buf_tail      <= '0;
            rd_count      <= '0;
            underflow_err <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (pop) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
            if (inflight_q && fifo_underflow) begin
                underflow_err <= 1'b1;
            end
            case ({pop, capture})
                2'b11: begin
                    if (occ == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= fifo_data_out;
                    end else begin
                        buf_head <= fifo_data_out;
                    end
                end
                2'b10: begin
                    if (occ == 2'd2) begin
                        buf_head <= buf_tail;
                    end
                    occ <= occ - 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd0) begin
                        buf_head <= fifo_data_out;
                    end else begin
                        buf_tail <= fifo_data_out;
                    end
                    occ <= occ + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT, read words are
// queued as expected beats and a negedge monitor compares every delivered beat.
module tb_fifo_rd_streamer;
    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_underflow = 1'b0;
    logic          fifo_rd_en;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [CW-1:0] rd_count;
    logic          underflow_err;

    always #5 clk = ~clk;

    fifo_rd_streamer #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
        .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .rd_count(rd_count), .underflow_err(underflow_err)
    );

    logic [W-1:0]  fq[$];
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  next_word = 16'h0001;
    int            uf_req = 0;
    int            uf_done = 0;
    int            rd_seen = 0;
    int            occ_m = 0;
    bit            inflight_m = 1'b0;
    bit            err_exp = 1'b0;
    logic [CW-1:0] cnt_m = '0;
    int            errors = 0;
    int            checks = 0;
    bit            started = 1'b0;
    bit            hold_prev = 1'b0;
    logic [W-1:0]  prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(next_word);
            next_word++;
        end
    endtask

    // FIFO model plus abstract buffer bookkeeping (occupancy, in-flight, counts)
    logic [W-1:0] w_pop;
    bit           pop_now;
    bit           cap_now;
    always @(posedge clk) begin
        pop_now = m_valid && m_ready;
        cap_now = inflight_m && !fifo_underflow;
        if (rst) begin
            occ_m          <= 0;
            inflight_m     <= 1'b0;
            err_exp        <= 1'b0;
            cnt_m          <= '0;
            fifo_underflow <= 1'b0;
            exp_q.delete();
        end else begin
            occ_m      <= occ_m + int'(cap_now) - int'(pop_now);
            inflight_m <= fifo_rd_en;
            if (inflight_m && fifo_underflow) err_exp <= 1'b1;
            if (pop_now) cnt_m <= cnt_m + 1'b1;
            if (fifo_rd_en) begin
                rd_seen++;
                if (uf_req != uf_done) begin
                    uf_done++;
                    fifo_underflow <= 1'b1;
                    fifo_data_out  <= W'($urandom);
                end else if (fq.size() > 0) begin
                    w_pop = fq.pop_front();
                    fifo_underflow <= 1'b0;
                    fifo_data_out  <= w_pop;
                    exp_q.push_back(w_pop);
                end else begin
                    fifo_underflow <= 1'b1;
                    fifo_data_out  <= W'($urandom);
                end
            end else begin
                fifo_underflow <= 1'b0;
                fifo_data_out  <= W'($urandom);
            end
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Monitor: compares beats against the scoreboard and the abstract model
    logic [W-1:0] exp_word;
    bit           exp_rd;
    always @(negedge clk) begin
        if (started) begin
            check("rd_count", 32'(rd_count), 32'(cnt_m));
            check("underflow_err", 32'(underflow_err), 32'(err_exp));
            check("m_valid", 32'(m_valid), 32'(occ_m != 0));
            check("credit_bound", 32'((occ_m + int'(inflight_m)) <= 2), 32'd1);
            exp_rd = !rst && enable && !fifo_empty &&
                     ((occ_m + int'(inflight_m) - int'(m_valid && m_ready)) < 2);
            check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
            if (hold_prev) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(exp_word));
                end
            end
            hold_prev = m_valid && !m_ready && !rst;
            prev_data = m_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            found;
        int            base_rd;
        logic [CW-1:0] base_cnt;

        // Reset with a non-empty FIFO
        rst = 1'b1;
        enable = 1'b1;
        preload(8);
        cyc(1);
        started = 1'b1;
        cyc(1);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_uf_err", 32'(underflow_err), 32'd0);

        // Streaming with latency check
        rst = 1'b0;
        m_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (fifo_rd_en) found = 1;
        end
        check("first_rd_seen", 32'(found), 32'd1);
        @(negedge clk);
        check("lat_n1_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(m_valid), 32'd1);
        check("lat_n2_data", 32'(m_data), 32'h0001);
        cyc(12);
        check("stream_count", 32'(rd_count), 32'd8);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure
        preload(12);
        cyc(4);
        m_ready = 1'b0;
        cyc(5);
        check("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
        check("bp_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        cyc(20);
        check("bp_drained", 32'(exp_q.size() + fq.size()), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) preload($urandom_range(1, 3));
            if ($urandom_range(0, 40) == 0) uf_req++;
            cyc(1);
        end
        enable = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 100 && (fq.size() != 0 || exp_q.size() != 0 || m_valid); k++) cyc(1);
        check("rand_drained", 32'(exp_q.size() + fq.size()), 32'd0);
        uf_req = uf_done;

        // Directed underflow, sticky through idle cycles
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        enable = 1'b0;
        preload(3);
        uf_req++;
        cyc(1);
        enable = 1'b1;
        cyc(10);
        check("uf_set", 32'(underflow_err), 32'd1);
        check("uf_beats", 32'(rd_count), 32'd3);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("uf_sticky", 32'(underflow_err), 32'd1);
        end

        // Enable dropped right after a read is issued
        preload(6);
        cyc(2);
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        base_rd = rd_seen;
        base_cnt = rd_count;
        cyc(20);
        check("en_drop_no_rd", 32'(rd_seen - base_rd), 32'd0);
        check("en_drop_delivered", 32'(CW'(rd_count - base_cnt)), 32'd1);
        check("en_drop_fifo_left", 32'(fq.size()), 32'd5);
        fq.delete();
        cyc(2);

        // Reset clears the sticky error; counter wraps after 17 beats
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        check("rst_clears_uf", 32'(underflow_err), 32'd0);
        preload(17);
        enable = 1'b1;
        m_ready = 1'b1;
        cyc(30);
        check("wrap_count", 32'(rd_count), 32'd1);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
Downstream consumer of the synchronous FIFO. It drains the FIFO's read port (rd_en / data_out / empty / underflow) and presents the words as a valid/ready stream to the next stage. A 2-entry output buffer with credit-based read issue hides the FIFO's one-cycle read latency. This sustains one word per cycle under continuous m_ready and never loses data under backpressure.

Parameters:
FIFO_WIDTH, 16, data word width; must match the FIFO.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  permits issuing new FIFO reads.
fifo_empty  input  1  FIFO empty flag.
fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted rd_en.
fifo_underflow  input  1  FIFO flags that the previous-cycle read hit empty.
fifo_rd_en  output  1  FIFO read request.
m_data  output  FIFO_WIDTH  stream data (registered).
m_valid  output  1  stream valid (registered).
m_ready  input  1  downstream ready.
rd_count  output  CNT_WIDTH  words delivered downstream (m_valid && m_ready beats).
underflow_err  output  1  sticky error: a read returned underflow.

Behaviour:
- Reset (rst high at clk edge): m_valid=0, m_data=0, fifo_rd_en=0, rd_count=0, underflow_err=0. Buffer occupancy is 0 and the in-flight flag is cleared. A reset mid-operation discards buffered and in-flight words.
- State:
  - occ: 0..2, buffered words.
  - inflight_q: 1 if fifo_rd_en was high last cycle.
  - pop = m_valid && m_ready.
- Read issue (combinational): fifo_rd_en = !rst && enable && !fifo_empty && (occ + inflight_q - pop) < 2.
  - occ + inflight_q never exceeds 2.
  - fifo_rd_en may depend combinationally on m_ready.
  - m_valid and m_data never depend combinationally on m_ready.
- Capture: when inflight_q=1 and fifo_underflow=0, fifo_data_out is written at the buffer tail at the end of that cycle.
- Underflow: when inflight_q=1 and fifo_underflow=1, no word is captured and underflow_err is set. underflow_err stays 1 until rst.
- Latency:
  - rd_en sampled at cycle N → data captured at end of N+1 → m_valid=1 at N+2, when the buffer was empty.
  - Steady state with m_ready=1: one beat per cycle.
- Output:
  - m_valid = (occ != 0); m_data = buffer head.
  - While m_valid && !m_ready, m_data and m_valid hold stable.
  - Strict FIFO order.
- Simultaneous pop and capture in the same cycle: occ is unchanged, the head advances, and the new word goes to the tail.
- Capture with occ=2 cannot occur; the credit rule guarantees it. The verification engineer asserts this.
- enable low: no new reads are issued. In-flight and buffered words still drain normally.
- rd_count increments by 1 per pop and wraps modulo 2^CNT_WIDTH.
- fifo_empty low with zero credit: fifo_rd_en stays 0; there is no overflow path.

Test Plan:
- Reset: rst=1 for 2 cycles with FIFO non-empty → fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0, underflow_err=0.
- Streaming: FIFO preloaded 0x0001..0x0008, enable=1, m_ready=1 → first m_valid 2 cycles after first fifo_rd_en. Then 8 consecutive beats 0x0001..0x0008 and rd_count=8.
- Backpressure: during streaming, m_ready=0 for 5 cycles →
  - fifo_rd_en drops once occ+inflight=2;
  - m_data holds its value, occ ≤ 2;
  - after m_ready=1, the sequence continues without loss or duplication.
- Underflow: fifo_underflow=1 in the cycle after a fifo_rd_en → no beat for that read, underflow_err=1 and remains 1 through 10 idle cycles until rst.
- Enable drop: enable=0 in the same cycle as a fifo_rd_en → that word is still delivered, and no further fifo_rd_en occurs with FIFO non-empty.
- Counter wrap: CNT_WIDTH=4, 17 beats delivered → rd_count=1.
